// File: rtl/hawk_axiwr_master.sv
//------------------------------------------------------------------------------
// hawk_axiwr_master
//
// Single-beat AXI4 write master for 64 B cacheline writes issued by the page
// write manager. A request is captured into registers, then issued as one AW
// beat and one W beat (awlen=0, awsize=64 B, INCR, wlast=1). AW and W are
// tracked independently, so either channel may complete first. The B
// response is checked against bresp and the expected ID. The result is
// reported as a one-cycle done pulse, with done_err as its qualifier. Only one
// transaction is outstanding at any time.
//
// Optional feature (macro HAWK_AXIWR_TIMEOUT_EN):
//   Adds a B-response watchdog. After TIMEOUT_CYCLES cycles in WAIT_B with no
//   B handshake, the transaction completes with done_err=1 and the sticky
//   timeout_o flag is set. In IDLE, bready is then held high until one late B
//   response has been consumed and discarded. When the macro is undefined, no
//   counter is built, timeout_o is tied low and WAIT_B waits indefinitely.
//
// Parameters:
//   AXI_ID          fixed AWID; a B response with any other BID is an error
//   TIMEOUT_CYCLES  watchdog limit in WAIT_B cycles (watchdog build only)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_addr/req_data/req_strb    64 B cacheline write payload
//   done, done_err                completion pulse and its error qualifier
//   aw*                           AXI write-address channel (single beat)
//   w*                            AXI write-data channel (single beat)
//   bid/bresp/bvalid/bready       AXI write-response channel
//   timeout_o                     sticky watchdog flag (0 without the macro)
//------------------------------------------------------------------------------
module hawk_axiwr_master #(
   parameter logic [3:0]  AXI_ID         = 4'd0,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic         clk,
   input  logic         rst,
   // request side
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [63:0]  req_addr,
   input  logic [511:0] req_data,
   input  logic [63:0]  req_strb,
   output logic         done,
   output logic         done_err,
   // AXI write-address channel
   output logic [3:0]   awid,
   output logic [63:0]  awaddr,
   output logic [7:0]   awlen,
   output logic [2:0]   awsize,
   output logic [1:0]   awburst,
   output logic         awvalid,
   input  logic         awready,
   // AXI write-data channel
   output logic [511:0] wdata,
   output logic [63:0]  wstrb,
   output logic         wlast,
   output logic         wvalid,
   input  logic         wready,
   // AXI write-response channel
   input  logic [3:0]   bid,
   input  logic [1:0]   bresp,
   input  logic         bvalid,
   output logic         bready,
   output logic         timeout_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_B,
      ST_RESP
   } state_e;

   state_e         state_q, state_d;
   logic [63:0]    addr_q, addr_d;
   logic [511:0]   data_q, data_d;
   logic [63:0]    strb_q, strb_d;
   logic           aw_pend_q, aw_pend_d;   // AW beat still owed to the slave
   logic           w_pend_q, w_pend_d;     // W beat still owed to the slave
   logic           err_q, err_d;           // error result reported in RESP

   logic           aw_hs;
   logic           w_hs;
   logic           expire;                 // watchdog limit reached this cycle
   logic           drain;                  // consume one late B while in IDLE

   if (TIMEOUT_CYCLES == 0) begin : g_cfg_check
      $error("hawk_axiwr_master: TIMEOUT_CYCLES must be nonzero");
   end

   //---------------------------------------------------------------------------
   // Fixed single-beat burst shape; the payload comes straight from the
   // capture registers with no byte swapping. The valids are gated by rst so
   // that they read low during the first reset cycle as well, before the
   // state registers have cleared.
   //---------------------------------------------------------------------------
   assign awid    = AXI_ID;
   assign awlen   = 8'd0;
   assign awsize  = 3'b110;
   assign awburst = 2'b01;
   assign wlast   = 1'b1;
   assign awaddr  = addr_q;
   assign wdata   = data_q;
   assign wstrb   = strb_q;
   assign awvalid = aw_pend_q & ~rst;
   assign wvalid  = w_pend_q & ~rst;

   assign aw_hs = awvalid & awready;
   assign w_hs  = wvalid & wready;

   //---------------------------------------------------------------------------
   // Next-state and output decode
   //---------------------------------------------------------------------------
   // NOTE: every signal written here receives a default value first, so no
   // path through the block can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      data_d    = data_q;
      strb_d    = strb_q;
      aw_pend_d = aw_pend_q;
      w_pend_d  = w_pend_q;
      err_d     = err_q;
      req_ready = 1'b0;
      bready    = 1'b0;
      done      = 1'b0;
      done_err  = 1'b0;

      if (!rst) begin
         unique case (state_q)
            ST_IDLE: begin
               req_ready = 1'b1;
               bready    = drain;
               if (req_valid) begin
                  addr_d    = req_addr;
                  data_d    = req_data;
                  strb_d    = req_strb;
                  aw_pend_d = 1'b1;
                  w_pend_d  = 1'b1;
                  err_d     = 1'b0;
                  state_d   = ST_SEND;
               end
            end

            ST_SEND: begin
               // Each channel retires on its own handshake. Both pend_d
               // values already include this cycle's handshakes, so the
               // state advances in the same cycle as the last one.
               if (aw_hs) aw_pend_d = 1'b0;
               if (w_hs)  w_pend_d  = 1'b0;
               if (!aw_pend_d && !w_pend_d) begin
                  state_d = ST_WAIT_B;
               end
            end

            ST_WAIT_B: begin
               // bready is high from the entry cycle, so a bvalid that is
               // already waiting is accepted at once.
               bready = 1'b1;
               if (bvalid) begin
                  err_d   = (bresp != 2'b00) || (bid != AXI_ID);
                  state_d = ST_RESP;
               end else if (expire) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end
            end

            ST_RESP: begin
               done     = 1'b1;
               done_err = err_q;
               state_d  = ST_IDLE;
            end

            default: state_d = ST_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only. Every flop
   // then samples the values from before the clock edge, whatever order the
   // blocks run in.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the payload registers are plain flops, not a memory. Clearing
         // them keeps awaddr/wdata/wstrb at a defined 0 after reset.
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         data_q    <= '0;
         strb_q    <= '0;
         aw_pend_q <= 1'b0;
         w_pend_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         strb_q    <= strb_d;
         aw_pend_q <= aw_pend_d;
         w_pend_q  <= w_pend_d;
         err_q     <= err_d;
      end
   end

`ifdef HAWK_AXIWR_TIMEOUT_EN
   //---------------------------------------------------------------------------
   // B-response watchdog
   //---------------------------------------------------------------------------
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
   logic             drain_q, drain_d;

   // The counter holds the number of WAIT_B cycles already spent, so the
   // TIMEOUT_CYCLES-th cycle without a B response is the one that expires.
   assign expire    = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign drain     = drain_q;
   assign timeout_o = timeout_q & ~rst;

   always_comb begin
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      drain_d   = drain_q;

      // The counter is held at zero outside WAIT_B, so it always starts
      // counting from zero when WAIT_B is entered.
      if (state_q != ST_WAIT_B) begin
         cnt_d = '0;
      end else if (!bvalid) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      if (state_q == ST_WAIT_B && !bvalid && expire) begin
         timeout_d = 1'b1;
         drain_d   = 1'b1;
      end

      // Only one orphaned response is expected; stop draining once it is taken.
      if (state_q == ST_IDLE && drain_q && bvalid) begin
         drain_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
         drain_q   <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
         drain_q   <= drain_d;
      end
   end
`else
   assign expire    = 1'b0;
   assign drain     = 1'b0;
   assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_hawk_axiwr_master.sv
`timescale 1ns/1ps
module tb_hawk_axiwr_master;

   localparam logic [3:0] TB_AXI_ID  = 4'd0;
   localparam int         TB_TIMEOUT = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid, req_ready;
   logic [63:0]  req_addr;
   logic [511:0] req_data;
   logic [63:0]  req_strb;
   logic         done, done_err;
   logic [3:0]   awid;
   logic [63:0]  awaddr;
   logic [7:0]   awlen;
   logic [2:0]   awsize;
   logic [1:0]   awburst;
   logic         awvalid, awready;
   logic [511:0] wdata;
   logic [63:0]  wstrb;
   logic         wlast, wvalid, wready;
   logic [3:0]   bid;
   logic [1:0]   bresp;
   logic         bvalid, bready;
   logic         timeout_o;

   hawk_axiwr_master #(
      .AXI_ID         (TB_AXI_ID),
      .TIMEOUT_CYCLES (TB_TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_strb  (req_strb),
      .done      (done),
      .done_err  (done_err),
      .awid      (awid),
      .awaddr    (awaddr),
      .awlen     (awlen),
      .awsize    (awsize),
      .awburst   (awburst),
      .awvalid   (awvalid),
      .awready   (awready),
      .wdata     (wdata),
      .wstrb     (wstrb),
      .wlast     (wlast),
      .wvalid    (wvalid),
      .wready    (wready),
      .bid       (bid),
      .bresp     (bresp),
      .bvalid    (bvalid),
      .bready    (bready),
      .timeout_o (timeout_o)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // slave responder configuration
   int         aw_delay = 0, w_delay = 0, b_delay = 0;
   logic [1:0] cfg_bresp = 2'b00;
   logic [3:0] cfg_bid   = 4'd0;
   bit         b_enable  = 1'b1;
   bit         b_discard = 1'b0;

   // responder state
   int aw_wait = 0, w_wait = 0, b_wait = 0;
   int aw_n = 0, w_n = 0, b_issued = 0;
   bit b_taken = 1'b0;

   // reference model: what each accepted request must produce
   logic [63:0]  exp_aw_q[$];
   logic [511:0] exp_data_q[$];
   logic [63:0]  exp_strb_q[$];
   bit           exp_err_q[$];
   logic [63:0]  aw_log[$];

   // observations
   int   done_cnt = 0, b_cnt = 0;
   int   acc_cyc = 0, aw_cyc = 0, w_cyc = 0, done_cyc = 0;
   int   aw_hi = 0, w_hi = 0;
   bit   prev_done = 1'b0;
   logic last_err, done_to;

   //---------------------------------------------------------------------------
   // AXI slave responder: programmable ready delays and B latency
   //---------------------------------------------------------------------------
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rst) begin
            awready = 1'b0;
            wready  = 1'b0;
            bvalid  = 1'b0;
         end else begin
            if (awvalid) begin
               if (aw_wait >= aw_delay) awready = 1'b1;
               else begin awready = 1'b0; aw_wait++; end
            end else begin
               awready = 1'b0; aw_wait = 0;
            end
            if (wvalid) begin
               if (w_wait >= w_delay) wready = 1'b1;
               else begin wready = 1'b0; w_wait++; end
            end else begin
               wready = 1'b0; w_wait = 0;
            end
            if (b_taken) begin
               bvalid = 1'b0; b_taken = 1'b0; b_wait = 0;
            end
            if (!bvalid && b_enable && aw_n > b_issued && w_n > b_issued) begin
               if (b_wait >= b_delay) begin
                  bvalid = 1'b1; bresp = cfg_bresp; bid = cfg_bid; b_issued++;
               end else begin
                  b_wait++;
               end
            end
         end
      end
   end

   //---------------------------------------------------------------------------
   // Monitor, sampled on the falling edge
   //---------------------------------------------------------------------------
   always @(negedge clk) begin
      if (!rst) begin
         if (req_valid && req_ready) begin
            exp_aw_q.push_back(req_addr);
            exp_data_q.push_back(req_data);
            exp_strb_q.push_back(req_strb);
            acc_cyc = cyc; aw_hi = 0; w_hi = 0;
         end
         if (awvalid) aw_hi++;
         if (wvalid)  w_hi++;
         checks++;
         if (req_ready && (awvalid || wvalid || done)) begin
            failures++;
            $display("FAIL req_ready_busy t=%0t req_ready=%b awvalid=%b wvalid=%b done=%b",
                     $time, req_ready, awvalid, wvalid, done);
         end
         checks++;
         if (!done && done_err) begin
            failures++;
            $display("FAIL done_err_without_done t=%0t done_err=%b required 0", $time, done_err);
         end
         if (awvalid && awready) begin
            logic [63:0] ea;
            aw_n++; aw_cyc = cyc; aw_log.push_back(awaddr);
            checks++;
            if (exp_aw_q.size() == 0) begin
               failures++;
               $display("FAIL aw_unexpected t=%0t awaddr=%h with no request pending", $time, awaddr);
            end else begin
               ea = exp_aw_q.pop_front();
               if (awaddr !== ea || awlen !== 8'd0 || awsize !== 3'b110 ||
                   awburst !== 2'b01 || awid !== TB_AXI_ID) begin
                  failures++;
                  $display("FAIL aw_beat awaddr=%h/%h awlen=%0d/0 awsize=%b/110 awburst=%b/01 awid=%0d/%0d",
                           awaddr, ea, awlen, awsize, awburst, awid, TB_AXI_ID);
               end
            end
         end
         if (wvalid && wready) begin
            logic [511:0] ed;
            logic [63:0]  es;
            w_n++; w_cyc = cyc;
            checks++;
            if (exp_data_q.size() == 0) begin
               failures++;
               $display("FAIL w_unexpected t=%0t with no request pending", $time);
            end else begin
               ed = exp_data_q.pop_front();
               es = exp_strb_q.pop_front();
               if (wdata !== ed || wstrb !== es || wlast !== 1'b1) begin
                  failures++;
                  $display("FAIL w_beat wdata=%h required %h wstrb=%h/%h wlast=%b/1",
                           wdata, ed, wstrb, es, wlast);
               end
            end
         end
         if (bvalid && bready) begin
            b_cnt++; b_taken = 1'b1;
            if (!b_discard) exp_err_q.push_back((cfg_bresp != 2'b00) || (cfg_bid != TB_AXI_ID));
         end
         if (done) begin
            bit ee;
            done_cnt++; done_cyc = cyc; last_err = done_err; done_to = timeout_o;
            checks++;
            if (prev_done) begin
               failures++;
               $display("FAIL done_width t=%0t done high on consecutive cycles", $time);
            end else if (exp_err_q.size() == 0) begin
               failures++;
               $display("FAIL done_unexpected t=%0t done=1 with no completed response", $time);
            end else begin
               ee = exp_err_q.pop_front();
               if (done_err !== ee) begin
                  failures++;
                  $display("FAIL done_err t=%0t done_err=%b required %b", $time, done_err, ee);
               end
            end
         end
         prev_done = done;
      end else begin
         prev_done = 1'b0;
      end
   end

   //---------------------------------------------------------------------------
   // Helpers
   //---------------------------------------------------------------------------
   function automatic logic [511:0] rand_line();
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [63:0] rand64();
      logic [63:0] v;
      v = {$urandom, $urandom};
      return v;
   endfunction

   task automatic clear_tb_state();
      exp_aw_q.delete(); exp_data_q.delete(); exp_strb_q.delete(); exp_err_q.delete();
      aw_n = 0; w_n = 0; b_issued = 0; b_wait = 0; aw_wait = 0; w_wait = 0;
      b_taken = 1'b0; bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
   endtask

   task automatic apply_reset(input int n);
      @(posedge clk); #1;
      rst = 1'b1; req_valid = 1'b0;
      clear_tb_state();
      repeat (n) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send_req(input logic [63:0] a, input logic [511:0] d,
                           input logic [63:0] s);
      bit ok = 1'b0;
      req_addr = a; req_data = d; req_strb = s; req_valid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (req_ready) ok = 1'b1;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL accept_wait req_ready stayed 0 for 100 cycles");
      end
   endtask

   task automatic wait_done(input int target, input int budget);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         @(negedge clk); n++;
      end
      checks++;
      if (done_cnt < target) begin
         failures++;
         $display("FAIL done_wait done_count=%0d required %0d within %0d cycles",
                  done_cnt, target, budget);
      end
      @(posedge clk); #1;
   endtask

   //---------------------------------------------------------------------------
   // Scenarios
   //---------------------------------------------------------------------------
   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0 || awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0 ||
          done !== 1'b0 || done_err !== 1'b0 || timeout_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl req_ready=%b awvalid=%b wvalid=%b bready=%b done=%b done_err=%b timeout_o=%b required all 0",
                  req_ready, awvalid, wvalid, bready, done, done_err, timeout_o);
      end
      checks++;
      if (awaddr !== 64'd0 || wdata !== 512'd0 || wstrb !== 64'd0) begin
         failures++;
         $display("FAIL reset_payload awaddr=%h wstrb=%h required 0", awaddr, wstrb);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_release req_ready=%b required 1 done=%b required 0", req_ready, done);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      int base = done_cnt;
      aw_delay = 0; w_delay = 0; b_delay = 0;
      cfg_bresp = 2'b00; cfg_bid = TB_AXI_ID; b_enable = 1'b1;
      send_req(64'hFFF6100000, rand_line(), {64{1'b1}});
      wait_done(base + 1, 50);
      checks++;
      if (aw_cyc - acc_cyc != 1 || w_cyc - acc_cyc != 1) begin
         failures++;
         $display("FAIL single_aw_w_cycle aw=%0d w=%0d required 1 after accept",
                  aw_cyc - acc_cyc, w_cyc - acc_cyc);
      end
      checks++;
      if (done_cyc - acc_cyc != 3 || last_err !== 1'b0) begin
         failures++;
         $display("FAIL single_done latency=%0d required 3 done_err=%b required 0",
                  done_cyc - acc_cyc, last_err);
      end
   endtask

   task automatic test_skew();
      int awd[2] = '{5, 0};
      int wd[2]  = '{0, 3};
      for (int k = 0; k < 2; k++) begin
         int base = done_cnt;
         int m;
         aw_delay = awd[k]; w_delay = wd[k]; b_delay = 0;
         m = (awd[k] > wd[k]) ? awd[k] : wd[k];
         send_req(rand64(), rand_line(), rand64());
         wait_done(base + 1, 60);
         repeat (4) @(negedge clk);
         checks++;
         if (aw_hi != awd[k] + 1 || w_hi != wd[k] + 1) begin
            failures++;
            $display("FAIL skew_valid_width case=%0d awvalid_cycles=%0d/%0d wvalid_cycles=%0d/%0d",
                     k, aw_hi, awd[k] + 1, w_hi, wd[k] + 1);
         end
         checks++;
         if (done_cnt != base + 1 || done_cyc - acc_cyc != 3 + m) begin
            failures++;
            $display("FAIL skew_done case=%0d dones=%0d/1 latency=%0d/%0d",
                     k, done_cnt - base, done_cyc - acc_cyc, 3 + m);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_error();
      logic [1:0] rs[5]  = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b00};
      logic [3:0] ids[5] = '{4'd0, 4'd5, 4'd0, 4'd5, 4'd0};
      aw_delay = 0; w_delay = 0; b_delay = 1;
      for (int k = 0; k < 5; k++) begin
         int base = done_cnt;
         bit ee;
         cfg_bresp = rs[k]; cfg_bid = ids[k];
         ee = (rs[k] != 2'b00) || (ids[k] != TB_AXI_ID);
         send_req(rand64(), rand_line(), rand64());
         wait_done(base + 1, 40);
         checks++;
         if (last_err !== ee) begin
            failures++;
            $display("FAIL error_resp bresp=%b bid=%0d done_err=%b required %b",
                     rs[k], ids[k], last_err, ee);
         end
      end
      cfg_bresp = 2'b00; cfg_bid = TB_AXI_ID;
   endtask

   task automatic test_back_to_back();
      logic [63:0] addrs[3];
      int base = done_cnt;
      int log0 = aw_log.size();
      int k = 0;
      aw_delay = 1; w_delay = 0; b_delay = 0;
      for (int i = 0; i < 3; i++) addrs[i] = rand64();
      req_addr = addrs[0]; req_data = rand_line(); req_strb = rand64(); req_valid = 1'b1;
      for (int t = 0; t < 200 && k < 3; t++) begin
         @(negedge clk);
         if (req_ready) begin
            k++;
            @(posedge clk); #1;
            if (k < 3) begin
               req_addr = addrs[k]; req_data = rand_line(); req_strb = rand64();
            end else begin
               req_valid = 1'b0;
            end
         end
      end
      req_valid = 1'b0;
      wait_done(base + 3, 100);
      repeat (4) @(negedge clk);
      checks++;
      if (k != 3 || done_cnt != base + 3) begin
         failures++;
         $display("FAIL b2b_count accepted=%0d dones=%0d required 3", k, done_cnt - base);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (aw_log.size() <= log0 + i || aw_log[log0 + i] !== addrs[i]) begin
            failures++;
            $display("FAIL b2b_order index=%0d awaddr=%h required %h", i,
                     (aw_log.size() > log0 + i) ? aw_log[log0 + i] : 64'hx, addrs[i]);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_send();
      int base = done_cnt;
      aw_delay = 20; w_delay = 20; b_delay = 0;
      send_req(rand64(), rand_line(), rand64());
      @(negedge clk);
      checks++;
      if (awvalid !== 1'b1 || wvalid !== 1'b1) begin
         failures++;
         $display("FAIL midrst_pre awvalid=%b wvalid=%b required 1", awvalid, wvalid);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      clear_tb_state();
      @(negedge clk);
      checks++;
      if (awvalid !== 1'b0 || req_ready !== 1'b0) begin
         failures++;
         $display("FAIL midrst_during awvalid=%b req_ready=%b required 0", awvalid, req_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (awvalid !== 1'b0 || wvalid !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL midrst_after awvalid=%b wvalid=%b required 0 req_ready=%b required 1",
                  awvalid, wvalid, req_ready);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (done_cnt != base) begin
         failures++;
         $display("FAIL midrst_no_done dones=%0d required 0", done_cnt - base);
      end
      @(posedge clk); #1;
      aw_delay = 0; w_delay = 0;
      send_req(rand64(), rand_line(), rand64());
      wait_done(base + 1, 40);
   endtask

   task automatic test_random();
      for (int t = 0; t < 8; t++) begin
         int base = done_cnt;
         int m;
         bit ee;
         aw_delay = $urandom_range(0, 4);
         w_delay  = $urandom_range(0, 4);
         b_delay  = $urandom_range(0, 3);
         cfg_bresp = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         cfg_bid   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : TB_AXI_ID;
         ee = (cfg_bresp != 2'b00) || (cfg_bid != TB_AXI_ID);
         m  = (aw_delay > w_delay) ? aw_delay : w_delay;
         send_req(rand64(), rand_line(), rand64());
         wait_done(base + 1, 60);
         checks++;
         if (done_cyc - acc_cyc != 3 + m + b_delay) begin
            failures++;
            $display("FAIL rand_latency iter=%0d latency=%0d required %0d",
                     t, done_cyc - acc_cyc, 3 + m + b_delay);
         end
         checks++;
         if (aw_hi != aw_delay + 1 || w_hi != w_delay + 1) begin
            failures++;
            $display("FAIL rand_valid_width iter=%0d aw=%0d/%0d w=%0d/%0d",
                     t, aw_hi, aw_delay + 1, w_hi, w_delay + 1);
         end
         checks++;
         if (last_err !== ee) begin
            failures++;
            $display("FAIL rand_done_err iter=%0d done_err=%b required %b", t, last_err, ee);
         end
      end
      cfg_bresp = 2'b00; cfg_bid = TB_AXI_ID;
   endtask

`ifdef HAWK_AXIWR_TIMEOUT_EN
   task automatic test_timeout();
      int base = done_cnt;
      int bb;
      aw_delay = 0; w_delay = 0; b_delay = 0; b_enable = 1'b0;
      cfg_bresp = 2'b00; cfg_bid = TB_AXI_ID;
      send_req(rand64(), rand_line(), rand64());
      exp_err_q.push_back(1'b1);
      wait_done(base + 1, 80);
      checks++;
      if (done_cyc - acc_cyc != 2 + TB_TIMEOUT || done_to !== 1'b1) begin
         failures++;
         $display("FAIL timeout_done latency=%0d required %0d timeout_o=%b required 1",
                  done_cyc - acc_cyc, 2 + TB_TIMEOUT, done_to);
      end
      @(negedge clk);
      checks++;
      if (timeout_o !== 1'b1 || bready !== 1'b1 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL timeout_idle timeout_o=%b bready=%b req_ready=%b required 1 1 1",
                  timeout_o, bready, req_ready);
      end
      @(posedge clk); #1;
      bb = b_cnt; b_discard = 1'b1; b_enable = 1'b1;
      repeat (6) @(negedge clk);
      checks++;
      if (b_cnt != bb + 1 || done_cnt != base + 1) begin
         failures++;
         $display("FAIL timeout_late_b b_handshakes=%0d required 1 extra dones=%0d required 0",
                  b_cnt - bb, done_cnt - base - 1);
      end
      checks++;
      if (bready !== 1'b0 || timeout_o !== 1'b1) begin
         failures++;
         $display("FAIL timeout_after_drain bready=%b required 0 timeout_o=%b required 1",
                  bready, timeout_o);
      end
      b_discard = 1'b0;
      apply_reset(2);
      @(negedge clk);
      checks++;
      if (timeout_o !== 1'b0) begin
         failures++;
         $display("FAIL timeout_clear timeout_o=%b required 0", timeout_o);
      end
      @(posedge clk); #1;
      base = done_cnt;
      send_req(rand64(), rand_line(), rand64());
      wait_done(base + 1, 40);
   endtask
`else
   task automatic test_no_timeout();
      int base = done_cnt;
      aw_delay = 0; w_delay = 0; b_delay = 3 * TB_TIMEOUT;
      cfg_bresp = 2'b00; cfg_bid = TB_AXI_ID;
      send_req(rand64(), rand_line(), rand64());
      wait_done(base + 1, 120);
      checks++;
      if (done_cyc - acc_cyc != 3 + 3 * TB_TIMEOUT || last_err !== 1'b0 || done_to !== 1'b0) begin
         failures++;
         $display("FAIL no_timeout latency=%0d required %0d done_err=%b timeout_o=%b required 0 0",
                  done_cyc - acc_cyc, 3 + 3 * TB_TIMEOUT, last_err, done_to);
      end
      b_delay = 0;
   endtask
`endif

   //---------------------------------------------------------------------------
   // Sequence
   //---------------------------------------------------------------------------
   initial begin
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_strb = '0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 4'd0;
      test_reset();
      test_single();
      test_skew();
      test_error();
      test_back_to_back();
      test_reset_mid_send();
      test_random();
`ifdef HAWK_AXIWR_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_watchdog simulation exceeded 50000 cycles");
      $fatal(1, "watchdog expired");
   end

endmodule
